// File: rtl/decoder_grant_sequencer.sv
// Round-robin owner of a shared one-hot select decoder: one grant at a time, held until release, then a 1-cycle gap.
// Grant 1 cycle after req; no backpressure, owner holds until rel/req drop. Optional forced release: `define TIMEOUT_EN.
module decoder_grant_sequencer #(
  parameter int N        = 16,
  parameter int IDXW     = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    rel,
  output logic            sel_en,
  output logic [IDXW-1:0] sel_idx,
  output logic [N-1:0]    sel_onehot,
  output logic            busy,
  output logic            timeout
);

  if (IDXW != $clog2(N)) begin : g_bad_idxw
    $error("IDXW must equal clog2(N)");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] sel_idx_q, sel_idx_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] rr_next;
  logic [IDXW:0]   cand;
  logic            found;
  logic            owner_release;
  logic            hold_expired;

  // First requester at or after rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(N)) begin
        cand = cand - (IDXW+1)'(N);
      end
      if (!found && req[cand[IDXW-1:0]]) begin
        winner = cand[IDXW-1:0];
        found  = 1'b1;
      end
    end
  end

  assign rr_next       = (sel_idx_q == IDXW'(N-1)) ? '0 : sel_idx_q + 1'b1;
  assign owner_release = rel[sel_idx_q] | ~req[sel_idx_q];

`ifdef TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;

  assign hold_expired = (state_q == BUSY) && (hold_cnt_q == HW'(MAX_HOLD - 1));
  assign timeout      = timeout_q;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    if (state_q == IDLE) begin
      hold_cnt_d = '0;
    end else if (state_q == BUSY) begin
      // A genuine release in the expiry cycle wins and suppresses the pulse.
      if (owner_release) begin
        hold_cnt_d = '0;
      end else if (hold_expired) begin
        hold_cnt_d = '0;
        timeout_d  = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (enable && (|req)) begin
          sel_idx_d = winner;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (owner_release || hold_expired) begin
          rr_ptr_d = rr_next;
          state_d  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign sel_en  = (state_q == BUSY);
  assign busy    = (state_q != IDLE);
  assign sel_idx = sel_idx_q;

  always_comb begin
    sel_onehot = '0;
    if (sel_en) begin
      sel_onehot[sel_idx_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_grant_sequencer.sv
// Directed bench for decoder_grant_sequencer (N=16, MAX_HOLD=4); define TIMEOUT_EN to exercise forced release.
module tb_decoder_grant_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] rel = '0;
  logic        sel_en;
  logic [3:0]  sel_idx;
  logic [15:0] sel_onehot;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_grant_sequencer #(.N(16), .IDXW(4), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .rel        (rel),
    .sel_en     (sel_en),
    .sel_idx    (sel_idx),
    .sel_onehot (sel_onehot),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    req     = '0;
    rel     = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({sel_en, busy, timeout, sel_idx, sel_onehot} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state: got en=%b busy=%b to=%b idx=%0d oh=%h, want all 0",
               sel_en, busy, timeout, sel_idx, sel_onehot);
    end
    enable = 1'b1;
    req    = 16'h0020;
    step();
    n_checks++;
    if (sel_en !== 1'b1 || sel_idx !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_pre_grant: got en=%b idx=%0d, want en=1 idx=5", sel_en, sel_idx);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (sel_en !== 1'b0 || sel_onehot !== 16'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got en=%b oh=%h busy=%b, want 0/0000/0", sel_en, sel_onehot, busy);
    end
    req = '0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (sel_en !== 1'b0 || busy !== 1'b0 || sel_onehot !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_idle_quiet: got en=%b busy=%b oh=%h, want 0/0/0000", sel_en, busy, sel_onehot);
      end
    end
    req = 16'h8001;
    step();
    n_checks++;
    if (sel_idx !== 4'd0 || sel_onehot !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_rr_ptr: got idx=%0d oh=%h, want idx=0 oh=0001", sel_idx, sel_onehot);
    end
  endtask

  task automatic test_single_grant();
    apply_reset();
    enable = 1'b1;
    req    = 16'h0008;
    step();
    n_checks++;
    if (sel_en !== 1'b1 || sel_idx !== 4'd3 || sel_onehot !== 16'h0008 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got en=%b idx=%0d oh=%h busy=%b, want 1/3/0008/1",
               sel_en, sel_idx, sel_onehot, busy);
    end
    rel = 16'h0008;
    step();
    rel = '0;
    req = '0;
    n_checks++;
    if (sel_en !== 1'b0 || sel_onehot !== 16'h0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap: got en=%b oh=%h busy=%b, want 0/0000/1", sel_en, sel_onehot, busy);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || sel_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b en=%b, want 0/0", busy, sel_en);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_oh [10];
    exp_oh = '{16'h0001, 16'h0000, 16'h0000, 16'h0010, 16'h0000,
               16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0001};
    apply_reset();
    enable = 1'b1;
    req    = 16'h8011;
    rel    = 16'h8011;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (sel_onehot !== exp_oh[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got oh=%h, want %h", i, sel_onehot, exp_oh[i]);
      end
    end
  endtask

  task automatic test_non_owner_release();
    apply_reset();
    enable = 1'b1;
    req    = 16'h0004;
    step();
    req = 16'h0005;
    rel = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (sel_en !== 1'b1 || sel_idx !== 4'd2) begin
        n_fail++;
        $display("FAIL nonowner_hold[%0d]: got en=%b idx=%0d, want 1/2", i, sel_en, sel_idx);
      end
    end
    rel = '0;
    req = 16'h0001;
    step();
    n_checks++;
    if (sel_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nonowner_drop_gap: got en=%b busy=%b, want 0/1", sel_en, busy);
    end
    step();
    step();
    n_checks++;
    if (sel_en !== 1'b1 || sel_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL nonowner_next: got en=%b idx=%0d, want 1/0", sel_en, sel_idx);
    end
  endtask

  task automatic test_enable_gating();
    apply_reset();
    enable = 1'b0;
    req    = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (sel_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL en_block[%0d]: got en=%b busy=%b, want 0/0", i, sel_en, busy);
      end
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (sel_en !== 1'b1 || sel_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL en_grant: got en=%b idx=%0d, want 1/1", sel_en, sel_idx);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (sel_en !== 1'b1) begin
        n_fail++;
        $display("FAIL en_fall_hold[%0d]: got en=%b, want 1", i, sel_en);
      end
    end
    rel = 16'h0002;
    step();
    rel = '0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (sel_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL en_no_regrant[%0d]: got en=%b busy=%b, want 0/0", i, sel_en, busy);
      end
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (sel_en !== 1'b1 || sel_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL en_regrant: got en=%b idx=%0d, want 1/1", sel_en, sel_idx);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    enable = 1'b1;
    req    = 16'h0008;
    step();
    req = 16'h0000;
    rel = 16'h0008;
    step();
    rel = '0;
    n_checks++;
    if (sel_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_gap: got en=%b busy=%b, want 0/1", sel_en, busy);
    end
    step();
    req = 16'h0018;
    step();
    n_checks++;
    if (sel_en !== 1'b1 || sel_idx !== 4'd4) begin
      n_fail++;
      $display("FAIL simul_single_advance: got en=%b idx=%0d, want 1/4", sel_en, sel_idx);
    end
  endtask

  task automatic test_hold_timeout();
    apply_reset();
    enable = 1'b1;
    req    = 16'h0041;
`ifdef TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (sel_en !== 1'b1 || sel_idx !== 4'd0 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold[%0d]: got en=%b idx=%0d to=%b, want 1/0/0", i, sel_en, sel_idx, timeout);
      end
    end
    step();
    n_checks++;
    if (sel_en !== 1'b0 || busy !== 1'b1 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_pulse: got en=%b busy=%b to=%b, want 0/1/1", sel_en, busy, timeout);
    end
    step();
    n_checks++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse_end: got to=%b busy=%b, want 0/0", timeout, busy);
    end
    step();
    n_checks++;
    if (sel_en !== 1'b1 || sel_idx !== 4'd6) begin
      n_fail++;
      $display("FAIL to_next_owner: got en=%b idx=%0d, want 1/6", sel_en, sel_idx);
    end
`else
    for (int i = 0; i < 120; i++) begin
      step();
      n_checks++;
      if (sel_en !== 1'b1 || sel_idx !== 4'd0 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_forever[%0d]: got en=%b idx=%0d to=%b, want 1/0/0", i, sel_en, sel_idx, timeout);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_non_owner_release();
    test_enable_gating();
    test_simultaneous();
    test_hold_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
